// File: rtl/step_seg_sequencer_if.sv
// Host segment stream and generator load bus shared by the segment sequencer,
// the host that feeds it and the acc_step_gen it drives.
interface step_seg_sequencer_if #(
  parameter int W = 32
);
  // Host command stream
  logic         cmd_valid;
  logic         cmd_ready;
  logic [W-1:0] cmd_dt;
  logic [W-1:0] cmd_steps;
  logic [4:0]   cmd_flags;   // [0]reset_dt [1]reset_steps [2]set_steps_limit [3]set_dt_limit [4]last

  // Generator load bus and status
  logic         gen_load;
  logic [W-1:0] gen_dt_val;
  logic [W-1:0] gen_steps_val;
  logic         gen_reset_dt;
  logic         gen_reset_steps;
  logic         gen_set_steps_limit;
  logic         gen_set_dt_limit;
  logic         gen_done;
  logic         gen_abort;

  // Sequencer side
  modport slave (
    input  cmd_valid, cmd_dt, cmd_steps, cmd_flags,
    output cmd_ready,
    output gen_load, gen_dt_val, gen_steps_val,
    output gen_reset_dt, gen_reset_steps, gen_set_steps_limit, gen_set_dt_limit,
    input  gen_done, gen_abort
  );

  // Host + generator side
  modport master (
    output cmd_valid, cmd_dt, cmd_steps, cmd_flags,
    input  cmd_ready,
    input  gen_load, gen_dt_val, gen_steps_val,
    input  gen_reset_dt, gen_reset_steps, gen_set_steps_limit, gen_set_dt_limit,
    output gen_done, gen_abort
  );
endinterface

// File: rtl/step_seg_sequencer.sv
// Segment scheduler in front of one acc_step_gen: buffers host motion segments
// in a small FIFO and issues one registered gen_load per segment, each landing
// the cycle after the generator reports done. A segment flagged "last" ends the
// job with a stop-load; an abort while starved is recorded as underrun.
module step_seg_sequencer #(
  parameter int DEPTH_LOG2 = 2,
  parameter int W          = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  step_seg_sequencer_if.slave   bus,
  input  logic                  start,
  input  logic                  stop,
  output logic                  busy,
  output logic                  underrun,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic [31:0]           seg_count
);

  localparam int DEPTH  = 2 ** DEPTH_LOG2;
  localparam int F_LAST = 4;

  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;
  localparam logic [DEPTH_LOG2:0]   LVL_ONE = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_WAIT_DATA,
    S_ABORTED
  } state_e;

  typedef struct packed {
    logic [W-1:0] dt;
    logic [W-1:0] steps;
    logic [4:0]   flags;
  } seg_t;

  state_e                state_q, state_d;
  seg_t                  mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   level_q;
  logic                  last_q;        // last flag of the segment now running
  logic                  underrun_q;
  logic [31:0]           seg_count_q;

  logic                  gen_load_q;
  logic [W-1:0]          gen_dt_q, gen_steps_q;
  logic [3:0]            gen_flags_q;

  logic full, empty, push, fifo_wr;
  logic pop, flush, load_seg, load_stop, seg_from_bus;
  logic count_restart, set_underrun, clr_underrun;
  seg_t cmd_seg, head, load_data;

  // The level counter reaches DEPTH only when its MSB is set.
  assign full    = level_q[DEPTH_LOG2];
  assign empty   = (level_q == '0);
  assign cmd_seg = {bus.cmd_dt, bus.cmd_steps, bus.cmd_flags};
  assign head    = mem_q[rd_ptr_q];

  assign bus.cmd_ready = !full && !stop;
  assign push          = bus.cmd_valid && bus.cmd_ready;
  // A push arriving while starved goes straight to the generator, never into storage.
  assign fifo_wr       = push && !seg_from_bus;
  assign load_data     = seg_from_bus ? cmd_seg : head;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and per-cycle control decisions; stop outranks everything else.
  // NOTE: every output of this block gets a default first, otherwise a latch is inferred.
  always_comb begin
    state_d       = state_q;
    pop           = 1'b0;
    flush         = 1'b0;
    load_seg      = 1'b0;
    load_stop     = 1'b0;
    seg_from_bus  = 1'b0;
    count_restart = 1'b0;
    set_underrun  = 1'b0;
    clr_underrun  = 1'b0;
    if (stop) begin
      flush = 1'b1;
      if (state_q != S_IDLE) begin
        load_stop = 1'b1;
        state_d   = S_IDLE;
      end
    end else begin
      case (state_q)
        S_IDLE, S_ABORTED: begin
          if (start && !empty) begin
            pop           = 1'b1;
            load_seg      = 1'b1;
            count_restart = 1'b1;
            clr_underrun  = 1'b1;
            state_d       = S_RUN;
          end
        end
        S_RUN: begin
          if (bus.gen_abort) begin
            set_underrun = 1'b1;
            state_d      = S_ABORTED;
          end else if (bus.gen_done) begin
            if (last_q) begin
              load_stop = 1'b1;
              state_d   = S_IDLE;
            end else if (!empty) begin
              pop      = 1'b1;
              load_seg = 1'b1;
            end else begin
              state_d = S_WAIT_DATA;
            end
          end
        end
        S_WAIT_DATA: begin
          if (push) begin
            seg_from_bus = 1'b1;
            load_seg     = 1'b1;
            state_d      = S_RUN;
          end else if (bus.gen_abort) begin
            set_underrun = 1'b1;
            state_d      = S_ABORTED;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Segment storage write port.
  // NOTE: storage is not reset; entries are only ever read while the level says they are valid.
  always_ff @(posedge clk) begin
    if (fifo_wr) mem_q[wr_ptr_q] <= cmd_seg;
  end

  // FIFO pointers and level; a flush empties the queue outright.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (fifo_wr) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)     rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({fifo_wr, pop})
        2'b10:   level_q <= level_q + LVL_ONE;
        2'b01:   level_q <= level_q - LVL_ONE;
        default: level_q <= level_q;
      endcase
    end
  end

  // Registered load pulse and payload to the generator; the stop-load sends all flags with zero values.
  always_ff @(posedge clk) begin
    if (reset) begin
      gen_load_q  <= 1'b0;
      gen_dt_q    <= '0;
      gen_steps_q <= '0;
      gen_flags_q <= '0;
    end else begin
      gen_load_q <= load_seg || load_stop;
      if (load_stop) begin
        gen_dt_q    <= '0;
        gen_steps_q <= '0;
        gen_flags_q <= 4'b1111;
      end else if (load_seg) begin
        gen_dt_q    <= load_data.dt;
        gen_steps_q <= load_data.steps;
        gen_flags_q <= load_data.flags[3:0];
      end
    end
  end

  // Job status: sticky underrun, segment counter and the running segment's last flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      underrun_q  <= 1'b0;
      seg_count_q <= '0;
      last_q      <= 1'b0;
    end else begin
      if (set_underrun)      underrun_q <= 1'b1;
      else if (clr_underrun) underrun_q <= 1'b0;
      if (load_seg) begin
        seg_count_q <= count_restart ? 32'd1 : seg_count_q + 32'd1;
        last_q      <= load_data.flags[F_LAST];
      end
    end
  end

  assign bus.gen_load            = gen_load_q;
  assign bus.gen_dt_val          = gen_dt_q;
  assign bus.gen_steps_val       = gen_steps_q;
  assign bus.gen_reset_dt        = gen_flags_q[0];
  assign bus.gen_reset_steps     = gen_flags_q[1];
  assign bus.gen_set_steps_limit = gen_flags_q[2];
  assign bus.gen_set_dt_limit    = gen_flags_q[3];

  assign busy       = (state_q != S_IDLE);
  assign underrun   = underrun_q;
  assign fifo_level = level_q;
  assign seg_count  = seg_count_q;

endmodule

// File: tb/tb_step_seg_sequencer.sv
// Self-checking bench for step_seg_sequencer: a queue-based model of the job
// rules is compared against the DUT every cycle, and directed scenarios pin
// hand-computed values at the points of interest.
module tb_step_seg_sequencer;

  localparam int DL = 2;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, stop;
  logic        busy, underrun;
  logic [DL:0] fifo_level;
  logic [31:0] seg_count;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  step_seg_sequencer_if #(.W(32)) bus ();

  step_seg_sequencer #(.DEPTH_LOG2(DL), .W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .start      (start),
    .stop       (stop),
    .busy       (busy),
    .underrun   (underrun),
    .fifo_level (fifo_level),
    .seg_count  (seg_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [31:0] dt;
    logic [31:0] st;
    logic [4:0]  f;
  } mseg_t;

  typedef enum {M_IDLE, M_RUN, M_WAIT, M_ABORT} mphase_e;

  mseg_t       mq[$];
  mphase_e     ph = M_IDLE;
  bit          m_last = 1'b0;
  bit          m_underrun = 1'b0;
  logic [31:0] m_count = '0;
  bit          e_load = 1'b0;
  logic [31:0] e_dt = '0, e_st = '0;
  logic [3:0]  e_fl = '0;

  task automatic issue(input mseg_t s);
    e_load = 1'b1;
    e_dt   = s.dt;
    e_st   = s.st;
    e_fl   = s.f[3:0];
    m_last = s.f[4];
  endtask

  task automatic issue_stop();
    e_load = 1'b1;
    e_dt   = '0;
    e_st   = '0;
    e_fl   = 4'b1111;
  endtask

  always @(posedge clk) begin
    mseg_t s, c;
    int    pre;
    bit    acc;
    pre = mq.size();
    acc = bus.cmd_valid && (pre < DEPTH) && !stop;
    c.dt = bus.cmd_dt;
    c.st = bus.cmd_steps;
    c.f  = bus.cmd_flags;
    e_load = 1'b0;
    if (reset) begin
      mq.delete();
      ph = M_IDLE;
      m_last = 1'b0;
      m_underrun = 1'b0;
      m_count = '0;
    end else if (stop) begin
      if (ph != M_IDLE) issue_stop();
      mq.delete();
      ph = M_IDLE;
    end else begin
      case (ph)
        M_IDLE, M_ABORT:
          if (start && pre > 0) begin
            s = mq.pop_front();
            issue(s);
            m_count = 32'd1;
            m_underrun = 1'b0;
            ph = M_RUN;
          end
        M_RUN:
          if (bus.gen_abort) begin
            m_underrun = 1'b1;
            ph = M_ABORT;
          end else if (bus.gen_done) begin
            if (m_last) begin
              issue_stop();
              ph = M_IDLE;
            end else if (pre > 0) begin
              s = mq.pop_front();
              issue(s);
              m_count = m_count + 32'd1;
            end else begin
              ph = M_WAIT;
            end
          end
        M_WAIT:
          if (acc) begin
            issue(c);
            m_count = m_count + 32'd1;
            acc = 1'b0;
            ph = M_RUN;
          end else if (bus.gen_abort) begin
            m_underrun = 1'b1;
            ph = M_ABORT;
          end
        default: ph = M_IDLE;
      endcase
      if (acc) mq.push_back(c);
    end
  end

  // Per-cycle comparison against the model, just after each active edge.
  always @(posedge clk) begin
    #1;
    if (cmp_en) begin
      check("m_gen_load", 64'(bus.gen_load), 64'(e_load));
      if (e_load) begin
        check("m_gen_dt", 64'(bus.gen_dt_val), 64'(e_dt));
        check("m_gen_steps", 64'(bus.gen_steps_val), 64'(e_st));
        check("m_gen_flags", 64'({bus.gen_set_dt_limit, bus.gen_set_steps_limit,
                                  bus.gen_reset_steps, bus.gen_reset_dt}), 64'(e_fl));
      end
      check("m_busy", 64'(busy), 64'(ph != M_IDLE));
      check("m_underrun", 64'(underrun), 64'(m_underrun));
      check("m_level", 64'(fifo_level), 64'(mq.size()));
      check("m_seg_count", 64'(seg_count), 64'(m_count));
      check("m_cmd_ready", 64'(bus.cmd_ready), 64'((mq.size() < DEPTH) && !stop));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] dt, input logic [31:0] st, input logic [4:0] f);
    bus.cmd_valid = 1'b1;
    bus.cmd_dt    = dt;
    bus.cmd_steps = st;
    bus.cmd_flags = f;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  task automatic pulse_done();
    bus.gen_done = 1'b1; tick(); bus.gen_done = 1'b0;
  endtask

  task automatic pulse_abort();
    bus.gen_abort = 1'b1; tick(); bus.gen_abort = 1'b0;
  endtask

  task automatic check_load(input string name, input logic [31:0] dt, input logic [31:0] st);
    check({name, "_load"}, 64'(bus.gen_load), 64'd1);
    check({name, "_dt"}, 64'(bus.gen_dt_val), 64'(dt));
    check({name, "_steps"}, 64'(bus.gen_steps_val), 64'(st));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_dt = '0; bus.cmd_steps = '0; bus.cmd_flags = '0;
    bus.gen_done = 1'b0; bus.gen_abort = 1'b0;
    tick();
    cmp_en = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();

    // Reset state
    check("rst_load", 64'(bus.gen_load), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_level", 64'(fifo_level), 64'd0);
    check("rst_count", 64'(seg_count), 64'd0);
    check("rst_ready", 64'(bus.cmd_ready), 64'd1);

    // 1: two segments, second one last
    push(32'd3, 32'd2, 5'b01111);
    push(32'd5, 32'd1, 5'b11000);
    check("t1_level", 64'(fifo_level), 64'd2);
    pulse_start();
    check_load("t1_a", 32'd3, 32'd2);
    check("t1_a_flags", 64'({bus.gen_set_dt_limit, bus.gen_set_steps_limit,
                             bus.gen_reset_steps, bus.gen_reset_dt}), 64'h0f);
    tick(); tick();
    pulse_done();
    check_load("t1_b", 32'd5, 32'd1);
    check("t1_b_count", 64'(seg_count), 64'd2);
    tick();
    pulse_done();
    check_load("t1_stop", 32'd0, 32'd0);
    check("t1_stop_flags", 64'({bus.gen_set_dt_limit, bus.gen_set_steps_limit,
                                bus.gen_reset_steps, bus.gen_reset_dt}), 64'h0f);
    tick();
    check("t1_busy", 64'(busy), 64'd0);
    check("t1_count", 64'(seg_count), 64'd2);
    check("t1_underrun", 64'(underrun), 64'd0);

    // 2: starve, then abort -> underrun; start with empty FIFO ignored
    push(32'd9, 32'd3, 5'b01111);
    pulse_start();
    check_load("t2_a", 32'd9, 32'd3);
    tick();
    pulse_done();
    check("t2_wait_load", 64'(bus.gen_load), 64'd0);
    tick();
    pulse_abort();
    check("t2_underrun", 64'(underrun), 64'd1);
    check("t2_busy", 64'(busy), 64'd1);
    repeat (3) tick();
    pulse_start();
    check("t2_ign_load", 64'(bus.gen_load), 64'd0);
    check("t2_ign_underrun", 64'(underrun), 64'd1);
    check("t2_ign_busy", 64'(busy), 64'd1);
    pulse_stop();
    check_load("t2_stopload", 32'd0, 32'd0);
    tick();

    // 3: data arrives while starved; then push coincident with abort
    push(32'd11, 32'd6, 5'b01111);
    pulse_start();
    check("t3_underrun_clr", 64'(underrun), 64'd0);
    tick();
    pulse_done();
    tick();
    push(32'd7, 32'd4, 5'b00000);
    check_load("t3_a", 32'd7, 32'd4);
    check("t3_underrun", 64'(underrun), 64'd0);
    check("t3_level", 64'(fifo_level), 64'd0);
    tick();
    pulse_done();
    bus.gen_abort = 1'b1;
    push(32'd13, 32'd2, 5'b10000);
    bus.gen_abort = 1'b0;
    check_load("t3_b", 32'd13, 32'd2);
    check("t3_b_underrun", 64'(underrun), 64'd0);
    tick();
    pulse_done();
    check_load("t3_stopload", 32'd0, 32'd0);
    tick();

    // 4: fill the FIFO; push blocked when full, even with a pop
    for (int i = 0; i < 4; i++) push(32'd20 + 32'(i), 32'd1 + 32'(i), 5'(i));
    check("t4_level", 64'(fifo_level), 64'd4);
    check("t4_ready", 64'(bus.cmd_ready), 64'd0);
    bus.cmd_valid = 1'b1; bus.cmd_dt = 32'd99; bus.cmd_steps = 32'd9; bus.cmd_flags = 5'b00000;
    tick(); tick();
    check("t4_level_hold", 64'(fifo_level), 64'd4);
    start = 1'b1; tick(); start = 1'b0;
    check("t4_level_pop", 64'(fifo_level), 64'd3);
    check_load("t4_a", 32'd20, 32'd1);
    tick();
    bus.cmd_valid = 1'b0;
    check("t4_level_refill", 64'(fifo_level), 64'd4);

    // 5: stop in RUN with two queued, coincident with gen_done
    pulse_done();
    check_load("t5_a", 32'd21, 32'd2);
    tick();
    pulse_done();
    check_load("t5_b", 32'd22, 32'd3);
    check("t5_level", 64'(fifo_level), 64'd2);
    tick();
    bus.gen_done = 1'b1; stop = 1'b1;
    tick();
    bus.gen_done = 1'b0; stop = 1'b0;
    check_load("t5_stopload", 32'd0, 32'd0);
    check("t5_level0", 64'(fifo_level), 64'd0);
    check("t5_busy", 64'(busy), 64'd0);
    tick();
    check("t5_single", 64'(bus.gen_load), 64'd0);

    // Stop in IDLE flushes only; start with empty FIFO ignored
    push(32'd1, 32'd1, 5'b00000);
    pulse_stop();
    check("t7_level", 64'(fifo_level), 64'd0);
    check("t7_noload", 64'(bus.gen_load), 64'd0);
    pulse_start();
    check("t7_busy", 64'(busy), 64'd0);

    // Abort during RUN is a protocol fault
    push(32'd30, 32'd5, 5'b00000);
    pulse_start();
    tick();
    pulse_abort();
    check("t8_underrun", 64'(underrun), 64'd1);
    check("t8_busy", 64'(busy), 64'd1);
    pulse_stop();
    tick();

    // 6: reset mid-RUN coincident with gen_done
    push(32'd40, 32'd2, 5'b00000);
    push(32'd41, 32'd3, 5'b00000);
    pulse_start();
    check_load("t6_a", 32'd40, 32'd2);
    tick();
    bus.gen_done = 1'b1; reset = 1'b1;
    tick();
    bus.gen_done = 1'b0;
    check("t6_load", 64'(bus.gen_load), 64'd0);
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_level", 64'(fifo_level), 64'd0);
    check("t6_count", 64'(seg_count), 64'd0);
    check("t6_underrun", 64'(underrun), 64'd0);
    check("t6_ready", 64'(bus.cmd_ready), 64'd1);
    reset = 1'b0;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
